// File: rtl/ct_spsram_2048x32_ctrl.sv
// Request-side controller for the 2048x32 single-port SRAM wrapper: fills the array with
// INIT_VAL after reset or inv_req, then issues reads/writes in order with a response FIFO.
module ct_spsram_2048x32_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 11,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int unsigned           RSP_DEPTH  = 4
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    input  logic                    inv_req,
    output logic                    init_busy,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_bmask,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q
);

    localparam int unsigned BMASK_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH   = $clog2(RSP_DEPTH);
    localparam int unsigned OCC_WIDTH   = PTR_WIDTH + 1;

    typedef enum logic {StInit = 1'b0, StIdle = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OCC_WIDTH-1:0]    occ_q, occ_d;
    logic                    rd_tag1_q, rd_tag1_d, rd_tag2_q;

    logic [ADDR_WIDTH-1:0]   a_q, a_d;
    logic                    cen_q, cen_d;
    logic                    gwen_q, gwen_d;
    logic [DATA_WIDTH-1:0]   wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   d_q, d_d;

    logic [DATA_WIDTH-1:0]   mem_q [RSP_DEPTH];
    logic [PTR_WIDTH-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_WIDTH:0]      fill_q;

    logic hs, rd_hs, wr_hs, push, pop;

    assign req_rdy   = (state_q == StIdle) && (occ_q < OCC_WIDTH'(RSP_DEPTH));
    assign init_busy = (state_q == StInit);
    assign hs        = req_vld && req_rdy;
    assign rd_hs     = hs && !req_wr;
    assign wr_hs     = hs && req_wr && (|req_bmask);
    // Q for a read is valid one cycle after the SRAM samples it, i.e. two edges after the
    // handshake; the second tag stage lines the push up with that.
    assign push      = rd_tag2_q;
    assign pop       = rsp_vld && rsp_rdy;

    assign rsp_vld   = (fill_q != '0);
    assign rsp_data  = mem_q[rd_ptr_q];

    assign sram_a    = a_q;
    assign sram_cen  = cen_q;
    assign sram_gwen = gwen_q;
    assign sram_wen  = wen_q;
    assign sram_d    = d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        d_d       = d_q;
        cen_d     = 1'b1;
        gwen_d    = 1'b1;
        wen_d     = '1;
        rd_tag1_d = 1'b0;
        case (state_q)
            StInit: begin
                a_d    = cnt_q;
                d_d    = INIT_VAL;
                cen_d  = 1'b0;
                gwen_d = 1'b0;
                wen_d  = '0;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == '1) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (rd_hs) begin
                    a_d       = req_addr;
                    cen_d     = 1'b0;
                    rd_tag1_d = 1'b1;
                end else if (wr_hs) begin
                    a_d    = req_addr;
                    d_d    = req_wdata;
                    cen_d  = 1'b0;
                    gwen_d = 1'b0;
                    for (int i = 0; i < BMASK_WIDTH; i++) begin
                        wen_d[8*i +: 8] = {8{~req_bmask[i]}};
                    end
                end
                // The request above still issues; init writes begin on the next edge.
                if (inv_req) begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({rd_hs, pop})
            2'b10:   occ_d = occ_q + OCC_WIDTH'(1);
            2'b01:   occ_d = occ_q - OCC_WIDTH'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            occ_q     <= '0;
            rd_tag1_q <= 1'b0;
            rd_tag2_q <= 1'b0;
            a_q       <= '0;
            cen_q     <= 1'b1;
            gwen_q    <= 1'b1;
            wen_q     <= '1;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            occ_q     <= occ_d;
            rd_tag1_q <= rd_tag1_d;
            rd_tag2_q <= rd_tag1_q;
            a_q       <= a_d;
            cen_q     <= cen_d;
            gwen_q    <= gwen_d;
            wen_q     <= wen_d;
            d_q       <= d_d;
        end
    end

    // occ bounds reads in flight plus stored entries, so a push never finds the FIFO full.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= sram_q;
                wr_ptr_q        <= wr_ptr_q + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   fill_q <= fill_q + (PTR_WIDTH+1)'(1);
                2'b01:   fill_q <= fill_q - (PTR_WIDTH+1)'(1);
                default: fill_q <= fill_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_spsram_2048x32_ctrl.sv
// Bench for ct_spsram_2048x32_ctrl: behavioural SRAM, word-level reference memory and an
// in-order expected-response queue, with directed steps followed by a random phase.
module tb_ct_spsram_2048x32_ctrl;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NENT = 1 << AW;
    localparam logic [DW-1:0] INIT_VAL = 32'h0;

    logic          clk;
    logic          cpurst_b;
    logic          inv_req;
    logic          init_busy;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [3:0]    req_bmask;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sram_mem [NENT];
    logic [DW-1:0] ref_mem  [NENT];
    logic [DW-1:0] exp_q [$];

    ct_spsram_2048x32_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VAL   (INIT_VAL),
        .RSP_DEPTH  (4)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (cpurst_b),
        .inv_req        (inv_req),
        .init_busy      (init_busy),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_bmask      (req_bmask),
        .rsp_vld        (rsp_vld),
        .rsp_rdy        (rsp_rdy),
        .rsp_data       (rsp_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: one-cycle read latency, per-bit active-low write enable.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (sram_gwen) sram_q <= sram_mem[sram_a];
            else sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < NENT; i++) ref_mem[i] = INIT_VAL;
    endtask

    // Reference: requests take effect on the word array in handshake order.
    always @(posedge clk) begin
        if (cpurst_b) begin
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) check("rsp_unexpected", rsp_vld, 1'b0);
                else check("rsp_data", rsp_data, exp_q.pop_front());
            end
            if (req_vld && req_rdy) begin
                if (req_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (req_bmask[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end else begin
                    exp_q.push_back(ref_mem[req_addr]);
                end
            end
            if (inv_req && !init_busy) model_init();
        end
    end

    // Called just after a negedge; returns at the negedge following the handshake edge.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] m);
        int n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = data; req_bmask = m;
        while (!req_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("req_rdy_timeout", req_rdy, 1'b1);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rsp_vld_timeout", rsp_vld, 1'b1);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp);
        rsp_rdy = 1'b0;
        issue(1'b0, addr, '0, 4'h0);
        wait_rsp();
        check(tag, rsp_data, exp);
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
    endtask

    task automatic wait_init_done();
        int n = 0;
        while (init_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("init_done", init_busy, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        rsp_rdy = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_rsp_vld", rsp_vld, 1'b0);
    endtask

    initial begin
        int accepts;
        int pops;
        int busy_cycles;
        logic [DW-1:0] wdat [4];

        cpurst_b = 1'b0; inv_req = 1'b0; req_vld = 1'b0; req_wr = 1'b0;
        req_addr = '0; req_wdata = '0; req_bmask = '0; rsp_rdy = 1'b0; sram_q = '0;
        for (int i = 0; i < NENT; i++) sram_mem[i] = $urandom;
        model_init();
        repeat (3) @(negedge clk);

        check("rst_ctl", {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
              {1'b1, 1'b1, 32'hFFFF_FFFF, 11'h0, 32'h0});
        check("rst_hs", {req_rdy, rsp_vld, rsp_data, init_busy}, {1'b0, 1'b0, 32'h0, 1'b1});

        cpurst_b = 1'b1;
        for (int k = 0; k < NENT; k++) begin
            @(negedge clk);
            check("init_a", sram_a, k);
            check("init_ctl", {sram_cen, sram_gwen, sram_wen, sram_d},
                  {1'b0, 1'b0, 32'h0, INIT_VAL});
            check("init_busy", init_busy, (k < NENT - 1));
        end
        check("init_req_rdy", req_rdy, 1'b1);
        @(negedge clk);
        check("idle_cen", sram_cen, 1'b1);

        issue(1'b1, 11'd5, 32'hA5A5_1234, 4'hF);
        check("wr_pins", {sram_a, sram_cen, sram_gwen, sram_wen, sram_d},
              {11'd5, 1'b0, 1'b0, 32'h0, 32'hA5A5_1234});
        rsp_rdy = 1'b0;
        issue(1'b0, 11'd5, '0, 4'h0);
        check("rd_pins", {sram_a, sram_cen, sram_gwen, sram_wen}, {11'd5, 1'b0, 1'b1, 32'hFFFF_FFFF});
        check("lat_e0", rsp_vld, 1'b0);
        @(negedge clk);
        check("lat_e1", rsp_vld, 1'b0);
        @(negedge clk);
        check("lat_e2", {rsp_vld, rsp_data}, {1'b1, 32'hA5A5_1234});
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;

        issue(1'b1, 11'd5, 32'hFFFF_FFFF, 4'b0010);
        check("bytewr_wen", sram_wen, 32'hFFFF_00FF);
        read_check("bytewr_rd", 11'd5, 32'hA5A5_FF34);
        issue(1'b1, 11'd9, 32'hDEAD_BEEF, 4'h0);
        check("nomask_pins", {sram_cen, sram_a}, {1'b1, 11'd5});
        read_check("nomask_rd", 11'd9, INIT_VAL);

        for (int i = 0; i < 4; i++) begin
            wdat[i] = $urandom;
            issue(1'b1, AW'(100 + i), wdat[i], 4'hF);
        end
        rsp_rdy = 1'b0;
        req_vld = 1'b1; req_wr = 1'b0;
        accepts = 0;
        for (int c = 0; c < 8; c++) begin
            req_addr = AW'(100 + accepts);
            if (req_rdy) accepts++;
            @(negedge clk);
        end
        req_vld = 1'b0;
        check("bp_accepts", accepts, 4);
        check("bp_rdy_low", req_rdy, 1'b0);
        check("bp_head", {rsp_vld, rsp_data}, {1'b1, wdat[0]});
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        check("bp_rdy_after_pop", req_rdy, 1'b1);
        check("bp_next", rsp_data, wdat[1]);
        drain();

        for (int c = 0; c < 600; c++) begin
            req_vld   = ($urandom_range(0, 3) != 0);
            req_wr    = $urandom_range(0, 1);
            req_addr  = AW'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_bmask = 4'($urandom_range(0, 15));
            rsp_rdy   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        req_vld = 1'b0;
        drain();

        rsp_rdy = 1'b0;
        issue(1'b0, 11'd5, '0, 4'h0);
        issue(1'b0, 11'd100, '0, 4'h0);
        repeat (3) @(negedge clk);
        inv_req = 1'b1;
        @(negedge clk);
        inv_req = 1'b0;
        rsp_rdy = 1'b1;
        pops = 0;
        busy_cycles = 0;
        while (init_busy && busy_cycles < 3000) begin
            if (rsp_vld && rsp_rdy) pops++;
            busy_cycles++;
            @(negedge clk);
        end
        check("inv_busy_cycles", busy_cycles, NENT);
        check("inv_pops_in_init", pops, 2);
        drain();
        read_check("inv_rd5", 11'd5, INIT_VAL);

        rsp_rdy = 1'b0;
        issue(1'b0, 11'd100, '0, 4'h0);
        issue(1'b0, 11'd101, '0, 4'h0);
        repeat (3) @(negedge clk);
        cpurst_b = 1'b0;
        #1;
        check("midrst_out", {rsp_vld, rsp_data, sram_cen, init_busy, req_rdy},
              {1'b0, 32'h0, 1'b1, 1'b1, 1'b0});
        exp_q.delete();
        model_init();
        @(negedge clk);
        cpurst_b = 1'b1;
        @(negedge clk);
        check("midrst_init0", {sram_a, sram_cen, sram_gwen}, {11'd0, 1'b0, 1'b0});
        wait_init_done();
        check("midrst_no_rsp", rsp_vld, 1'b0);
        read_check("midrst_rd5", 11'd5, INIT_VAL);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ct_spsram_2048x32_ctrl.md
# ct_spsram_2048x32_ctrl

Request-side controller placed directly upstream of the 2048x32 single-port split SRAM wrapper. It turns a valid/ready read/write request stream into registered SRAM pin activity (A, CEN, GWEN, WEN, D) and captures the one-cycle-latency Q into a response FIFO with valid/ready backpressure. After reset, and on demand, a state machine writes INIT_VAL to all 2048 entries before any request is accepted.

## Interface
- ADDR_WIDTH, 11, SRAM address width; entry count is 2^ADDR_WIDTH.
- DATA_WIDTH, 32, data width; byte-mask width is DATA_WIDTH/8.
- INIT_VAL, 32'h0, value written to every entry during init.
- RSP_DEPTH, 4, response FIFO depth (power of 2, ≥4).
- forever_cpuclk  in  1  clock; also drives the SRAM CLK.
- cpurst_b  in  1  reset, asynchronous, active-low.
- inv_req  in  1  start a full re-initialization; sampled only in IDLE.
- init_busy  out  1  high while in INIT.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_bmask  in  DATA_WIDTH/8  byte enables, 1 = write byte.
- rsp_vld  out  1  read data valid.
- rsp_rdy  in  1  consumer ready.
- rsp_data  out  DATA_WIDTH  read data.
- sram_a  out  ADDR_WIDTH  to SRAM A.
- sram_cen  out  1  to SRAM CEN, active-low.
- sram_gwen  out  1  to SRAM GWEN, active-low global write.
- sram_wen  out  DATA_WIDTH  to SRAM WEN, active-low per bit.
- sram_d  out  DATA_WIDTH  to SRAM D.
- sram_q  in  DATA_WIDTH  from SRAM Q.

## Operation
- States: INIT and IDLE. Reset enters INIT with counter 0.
- INIT: each cycle loads the SRAM flops with a write of INIT_VAL to counter (cen 0, gwen 0, wen all 0), then increments the counter. A write at counter 2^ADDR_WIDTH-1 moves the state to IDLE. inv_req is ignored in INIT. req_rdy is 0.
- IDLE: inv_req=1 moves to INIT with counter 0. A request handshaken in the same cycle still issues; init writes start one cycle later.
- req_rdy = (state==IDLE) && (occ < RSP_DEPTH). It depends only on flops, never on req_vld, req_wr or rsp_rdy.
- occ counts reads in flight plus FIFO entries. It increments on read handshake and decrements on rsp handshake; both in one cycle leave it unchanged.
- Read: SRAM flops load cen 0, gwen 1, wen all 1, a=req_addr.
- Write: a=req_addr, d=req_wdata, sram_wen[8i+7:8i]=~{8{req_bmask[i]}}, gwen 0, cen 0. A write with bmask=0 is accepted with no SRAM access (cen 1). Writes do not change occ.
- No handshake and not INIT: SRAM flops go idle (cen 1, gwen 1, wen all 1). a and d hold their values.
- A read-tag pipeline tracks which SRAM cycles are reads. sram_q is pushed into the FIFO in the cycle after the SRAM access.
- FIFO pops on rsp_vld && rsp_rdy. rsp_data is stable while rsp_vld && !rsp_rdy. Responses are returned in request order.
- Responses still pending when inv_req is taken remain deliverable during INIT.
- A read-after-write to the same address in back-to-back cycles returns the new data, because the SRAM accesses occur in order.

## Timing
- Reset values: sram_cen 1, sram_gwen 1, sram_wen all 1, sram_a 0, sram_d 0, req_rdy 0, rsp_vld 0, rsp_data 0, init_busy 1, occ 0, FIFO empty.
- Reset asserted mid-operation clears everything, drops all pending responses and restarts INIT.
- init_busy is high for exactly 2^ADDR_WIDTH cycles after reset release (or after inv_req is taken). req_rdy can rise the cycle after the final init write is loaded.
- Read latency: handshake at edge E0, SRAM driven E0→E1, Q valid after E1, FIFO push at E2, rsp_vld high in the cycle after E2. That is 2 cycles, with no combinational path from sram_q to rsp_data.
- With RSP_DEPTH=4 and rsp_rdy held at 1, the block sustains one read per cycle.
- SRAM pins are registered outputs only.

## Test plan
- Reset release: init_busy=1 for 2048 cycles with sram_a stepping 0..2047, gwen=0, wen=0, d=0. Then req_rdy=1 and sram_cen=1.
- Write addr 5 data 32'hA5A5_1234 bmask 4'hF, then read addr 5 → rsp_vld 2 cycles after the read handshake, rsp_data=32'hA5A5_1234.
- Byte write addr 5 data 32'hFFFF_FFFF bmask 4'b0010 → sram_wen=32'hFFFF_00FF. Readback gives 32'hA5A5_FF34.
- Hold rsp_rdy=0 and issue reads → exactly 4 accepted, then req_rdy=0. Raising rsp_rdy drains the data in order, with one new accept per pop.
- inv_req with 2 responses pending → both delivered during INIT. After INIT, a read of addr 5 returns 0.
- Assert cpurst_b low mid-stream with responses queued → rsp_vld=0 immediately, responses lost, INIT restarts from address 0.
